// File: rtl/alu_flag_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_flag_stage_if
//  Brief    : Handshake bundle between the ALU datapath, the flag stage and
//             the downstream consumer (input side plus output side).
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_flag_stage_if #(
    parameter int WIDTH = 32
);
    // Producer -> stage
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_ovf;
    logic [3:0]       in_flag_mask;

    // Stage -> consumer
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       flags;

    // Environment side: drives the ALU inputs and the consumer ready
    modport master (
        output in_valid,
        output in_result,
        output in_carry,
        output in_ovf,
        output in_flag_mask,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  flags
    );

    // Flag stage side
    modport slave (
        input  in_valid,
        input  in_result,
        input  in_carry,
        input  in_ovf,
        input  in_flag_mask,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module   : check_zero
//  Brief    : 32-bit zero detector used to derive the Z flag.
//  Revision : 1.0 - initial release
// ============================================================================
module check_zero (
    input  wire logic [31:0] a,
    output logic             z
);
    assign z = (a == 32'd0);
endmodule

// ============================================================================
//  Module   : alu_flag_stage
//  Brief    : Single-entry registered output stage behind the ALU. Holds the
//             result, the masked ZNCV flag register, a sticky overflow bit
//             and a wrapping completed-operation counter.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_flag_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    alu_flag_stage_if.slave       bus,
    input  wire logic             clr_sticky,
    output logic                  sticky_v,
    output logic [CNT_W-1:0]      op_count
);
    // Occupancy of the single pipeline register
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_zero;
    logic [3:0]       w_derived;
    logic [3:0]       w_flags_next;

    // The register frees up in the same cycle the consumer takes it
    assign w_in_ready = (r_state == S_EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;

    generate
        if (WIDTH == 32) begin : g_zero_32
            check_zero u_check_zero (
                .a (bus.in_result),
                .z (w_zero)
            );
        end else begin : g_zero_generic
            assign w_zero = ~|bus.in_result;
        end
    endgenerate

    // Flag order is {Z,N,C,V}; masked-off bits keep their previous value
    assign w_derived    = {w_zero, bus.in_result[WIDTH-1], bus.in_carry, bus.in_ovf};
    assign w_flags_next = (w_derived & bus.in_flag_mask) | (r_flags & ~bus.in_flag_mask);

    // Occupancy FSM: accept fills (or refills), drain without accept empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) r_state <= S_FULL;
                S_FULL:  if (bus.out_ready && !w_accept) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // Result, flags and counter only move on accept, so unaccepted inputs never leak in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_flags  <= 4'b0000;
            r_count  <= '0;
        end else if (w_accept) begin
            r_result <= bus.in_result;
            r_flags  <= w_flags_next;
            r_count  <= r_count + CNT_W'(1);
        end
    end

    // Sticky overflow: a qualifying overflow beats a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_accept && bus.in_flag_mask[0] && bus.in_ovf) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = (r_state == S_FULL);
    assign bus.out_result = r_result;
    assign bus.flags      = r_flags;
    assign sticky_v       = r_sticky;
    assign op_count       = r_count;
endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_flag_stage
//  Brief    : Directed scoreboard bench for alu_flag_stage (CNT_W = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_flag_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       clr_sticky;
    logic       sticky_v;
    logic [3:0] op_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];

    alu_flag_stage_if #(.WIDTH(32)) bus ();

    alu_flag_stage #(
        .WIDTH (32),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_sticky (clr_sticky),
        .sticky_v   (sticky_v),
        .op_count   (op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one operation, wait (bounded) for acceptance, log the expectation
    task automatic send(input logic [31:0] r, input logic c, input logic o,
                        input logic [3:0] m, input logic clr,
                        input logic [3:0] ef, input logic [3:0] ec, input logic es);
        int n = 0;
        bus.in_valid     = 1'b1;
        bus.in_result    = r;
        bus.in_carry     = c;
        bus.in_ovf       = o;
        bus.in_flag_mask = m;
        clr_sticky       = clr;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
            bus.in_valid = 1'b0;
            clr_sticky   = 1'b0;
        end else begin
            @(posedge clk); #1;
            sb.push_back('{r, ef, ec});
            bus.in_valid = 1'b0;
            clr_sticky   = 1'b0;
            check("flags_after_accept", {28'd0, bus.flags}, {28'd0, ef});
            check("op_count_after_accept", {28'd0, op_count}, {28'd0, ec});
            check("sticky_after_accept", {31'd0, sticky_v}, {31'd0, es});
        end
    endtask

    // Monitor: compare the held output against the oldest expectation, pop on transfer
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h required=no_output", bus.out_result);
                end else begin
                    check("mon_result", bus.out_result, sb[0].result);
                    check("mon_flags", {28'd0, bus.flags}, {28'd0, sb[0].flags});
                    check("mon_op_count", {28'd0, op_count}, {28'd0, sb[0].cnt});
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        clr_sticky       = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_result    = 32'd0;
        bus.in_carry     = 1'b0;
        bus.in_ovf       = 1'b0;
        bus.in_flag_mask = 4'd0;
        bus.out_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_out_result", bus.out_result, 32'd0);
        check("reset_flags", {28'd0, bus.flags}, 32'd0);
        check("reset_op_count", {28'd0, op_count}, 32'd0);
        check("reset_sticky", {31'd0, sticky_v}, 32'd0);
        check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Zero then negative, full mask
        send(32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b1010, 4'd1, 1'b0);
        send(32'h8000_0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0101, 4'd2, 1'b1);
        // Back to 1010, then masked updates
        send(32'h0000_0000, 1'b1, 1'b0, 4'b1111, 1'b0, 4'b1010, 4'd3, 1'b1);
        send(32'h0000_0001, 1'b0, 1'b0, 4'b1000, 1'b0, 4'b0010, 4'd4, 1'b1);
        send(32'h8000_0001, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0110, 4'd5, 1'b1);

        // Software clear of sticky_v
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        check("sticky_cleared", {31'd0, sticky_v}, 32'd0);

        // Empty mask: flags hold, count advances, overflow does not stick
        send(32'h0000_0000, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0110, 4'd6, 1'b0);

        // Backpressure: A held while B waits three cycles
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(32'h1234_5678, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'd7, 1'b0);
        bus.in_valid     = 1'b1;
        bus.in_result    = 32'hDEAD_BEEF;
        bus.in_carry     = 1'b1;
        bus.in_ovf       = 1'b0;
        bus.in_flag_mask = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        sb.push_back('{32'hDEAD_BEEF, 4'b0110, 4'd8});
        bus.in_valid = 1'b0;
        check("replace_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("replace_op_count", {28'd0, op_count}, 32'd8);

        // Overflow and clear in the same cycle: set wins
        send(32'h0000_0007, 1'b0, 1'b1, 4'b0001, 1'b1, 4'b0111, 4'd9, 1'b1);
        clr_sticky = 1'b1;
        @(posedge clk); #1;
        clr_sticky = 1'b0;
        check("sticky_clear_alone", {31'd0, sticky_v}, 32'd0);

        // Asynchronous reset while a result is held
        bus.out_ready = 1'b0;
        send(32'h0000_0055, 1'b0, 1'b0, 4'b1111, 1'b0, 4'b0000, 4'd10, 1'b0);
        #1 rst = 1'b1;
        #2;
        sb.delete();
        check("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async_rst_out_result", bus.out_result, 32'd0);
        check("async_rst_flags", {28'd0, bus.flags}, 32'd0);
        check("async_rst_op_count", {28'd0, op_count}, 32'd0);
        check("async_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #4 rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);

        // Seventeen back-to-back accepts wrap the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            bus.in_valid     = 1'b1;
            bus.in_result    = 32'(i + 1);
            bus.in_carry     = i[0];
            bus.in_ovf       = 1'b0;
            bus.in_flag_mask = 4'b1111;
            check("wrap_in_ready", {31'd0, bus.in_ready}, 32'd1);
            @(posedge clk); #1;
            sb.push_back('{32'(i + 1), {2'b00, i[0], 1'b0}, 4'(i + 1)});
            check("wrap_out_valid", {31'd0, bus.out_valid}, 32'd1);
            if (i == 15) check("wrap_count_16", {28'd0, op_count}, 32'd0);
            if (i == 16) check("wrap_count_17", {28'd0, op_count}, 32'd1);
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        check("final_idle", {31'd0, bus.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
